// File: rtl/fpu_pkg.sv
// Shared COP1 encodings, FPU op selects, controller state and default latencies
// for the FPU issue controller and the instruction decode tables.
package fpu_pkg;

  localparam logic [5:0] OPC_COP1  = 6'h11;

  localparam logic [4:0] FOP_MFC1  = 5'h00;
  localparam logic [4:0] FOP_MTC1  = 5'h04;
  localparam logic [4:0] FOP_ARITH = 5'h10;

  localparam logic [5:0] FN_ADD = 6'h00;
  localparam logic [5:0] FN_SUB = 6'h01;
  localparam logic [5:0] FN_MUL = 6'h02;
  localparam logic [5:0] FN_DIV = 6'h03;
  localparam logic [5:0] FN_MOV = 6'h06;
  localparam logic [5:0] FN_CEQ = 6'h32;
  localparam logic [5:0] FN_CLT = 6'h3C;
  localparam logic [5:0] FN_CLE = 6'h3E;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOV = 3'd4;
  localparam logic [2:0] OP_CEQ = 3'd5;
  localparam logic [2:0] OP_CLT = 3'd6;
  localparam logic [2:0] OP_CLE = 3'd7;

  localparam int LAT_ADD_DEF = 3;
  localparam int LAT_MUL_DEF = 4;
  localparam int LAT_DIV_DEF = 10;
  localparam int LAT_MOV_DEF = 1;
  localparam int LAT_CMP_DEF = 2;
  localparam int CNT_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0] opc;
    logic [4:0] fop;
    logic [4:0] ft;
    logic [4:0] fs;
    logic [4:0] fd;
    logic [5:0] fn;
  } inst_t;

  // Compare ops occupy the top of the op_sel space and only ever write a flag.
  function automatic logic is_cmp_op(input logic [2:0] op);
    return (op == OP_CEQ) || (op == OP_CLT) || (op == OP_CLE);
  endfunction

endpackage

// File: rtl/fpu_lat_decode.sv
// Combinational COP1 decode: legality, FPU op select, writeback latency and
// write-target class for one instruction.
module fpu_lat_decode
  import fpu_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF,
  parameter int LAT_MOV = LAT_MOV_DEF,
  parameter int LAT_CMP = LAT_CMP_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic [5:0]       opc_i,
  input  logic [4:0]       fop_i,
  input  logic [5:0]       fn_i,
  output logic             is_cop1_o,
  output logic             legal_o,
  output logic [2:0]       op_sel_o,
  output logic [CNT_W-1:0] latency_o,
  output logic             is_cmp_o,
  output logic             from_cpu_o,
  output logic             is_mfc1_o
);

  logic arith_legal;

  always_comb begin
    arith_legal = 1'b1;
    op_sel_o    = OP_ADD;
    latency_o   = CNT_W'(LAT_ADD);
    unique case (fn_i)
      FN_ADD: begin op_sel_o = OP_ADD; latency_o = CNT_W'(LAT_ADD); end
      FN_SUB: begin op_sel_o = OP_SUB; latency_o = CNT_W'(LAT_ADD); end
      FN_MUL: begin op_sel_o = OP_MUL; latency_o = CNT_W'(LAT_MUL); end
      FN_DIV: begin op_sel_o = OP_DIV; latency_o = CNT_W'(LAT_DIV); end
      FN_MOV: begin op_sel_o = OP_MOV; latency_o = CNT_W'(LAT_MOV); end
      FN_CEQ: begin op_sel_o = OP_CEQ; latency_o = CNT_W'(LAT_CMP); end
      FN_CLT: begin op_sel_o = OP_CLT; latency_o = CNT_W'(LAT_CMP); end
      FN_CLE: begin op_sel_o = OP_CLE; latency_o = CNT_W'(LAT_CMP); end
      default: arith_legal = 1'b0;
    endcase

    is_cop1_o  = (opc_i == OPC_COP1);
    legal_o    = 1'b0;
    is_cmp_o   = 1'b0;
    from_cpu_o = 1'b0;
    is_mfc1_o  = 1'b0;

    if (fop_i == FOP_MFC1) begin
      legal_o   = 1'b1;
      is_mfc1_o = 1'b1;
      op_sel_o  = OP_MOV;
      latency_o = CNT_W'(LAT_MOV);
    end else if (fop_i == FOP_MTC1) begin
      legal_o    = 1'b1;
      from_cpu_o = 1'b1;
      op_sel_o   = OP_MOV;
      latency_o  = CNT_W'(LAT_MOV);
    end else if (fop_i == FOP_ARITH) begin
      legal_o  = arith_legal;
      is_cmp_o = arith_legal && is_cmp_op(op_sel_o);
    end

    // Non-COP1 words are never legal FPU work.
    if (!is_cop1_o) begin
      legal_o    = 1'b0;
      is_cmp_o   = 1'b0;
      from_cpu_o = 1'b0;
      is_mfc1_o  = 1'b0;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-issue COP1 sequencer: accepts one instruction, holds operand selects
// for the op latency and emits exactly one register or flag write.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF,
  parameter int LAT_MOV = LAT_MOV_DEF,
  parameter int LAT_CMP = LAT_CMP_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [2:0]  fpu_op,
  output logic [4:0]  fpu_fs,
  output logic [4:0]  fpu_ft,
  output logic        wb_en,
  output logic [4:0]  wb_fd,
  output logic        wb_from_cpu,
  output logic [31:0] wb_data,
  output logic        flag_en,
  output logic [2:0]  flag_idx,
  output logic        mfc1_valid,
  output logic        illegal
);

  inst_t            inst;
  logic             dec_cop1;
  logic             dec_legal;
  logic [2:0]       dec_op;
  logic [CNT_W-1:0] dec_lat;
  logic             dec_cmp;
  logic             dec_from_cpu;
  logic             dec_mfc1;
  logic             accept;
  logic [CNT_W-1:0] cnt_d;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic [2:0]       op_q;
  logic [4:0]       fs_q;
  logic [4:0]       ft_q;
  logic [4:0]       fd_q;
  logic             is_cmp_q;
  logic             from_cpu_q;
  logic [31:0]      data_q;
  logic             wb_en_q;
  logic             flag_en_q;
  logic             mfc1_valid_q;
  logic             illegal_q;

  assign inst = inst_t'(in_inst);

  fpu_lat_decode #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_MOV (LAT_MOV),
    .LAT_CMP (LAT_CMP),
    .CNT_W   (CNT_W)
  ) u_dec (
    .opc_i      (inst.opc),
    .fop_i      (inst.fop),
    .fn_i       (inst.fn),
    .is_cop1_o  (dec_cop1),
    .legal_o    (dec_legal),
    .op_sel_o   (dec_op),
    .latency_o  (dec_lat),
    .is_cmp_o   (dec_cmp),
    .from_cpu_o (dec_from_cpu),
    .is_mfc1_o  (dec_mfc1)
  );

  // in_ready_q is only ever high in IDLE, so it alone qualifies the accept.
  assign accept = in_valid && in_ready_q;

  // EXEC spends LAT-2 cycles counting plus the cycle that sees zero.
  assign cnt_d = dec_lat - CNT_W'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      op_q         <= '0;
      fs_q         <= '0;
      ft_q         <= '0;
      fd_q         <= '0;
      is_cmp_q     <= 1'b0;
      from_cpu_q   <= 1'b0;
      data_q       <= '0;
      wb_en_q      <= 1'b0;
      flag_en_q    <= 1'b0;
      mfc1_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      wb_en_q      <= 1'b0;
      flag_en_q    <= 1'b0;
      mfc1_valid_q <= 1'b0;
      illegal_q    <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (accept && dec_cop1) begin
            if (!dec_legal) begin
              illegal_q <= 1'b1;
            end else begin
              op_q       <= dec_op;
              fs_q       <= inst.fs;
              ft_q       <= inst.ft;
              fd_q       <= inst.fd;
              is_cmp_q   <= dec_cmp;
              from_cpu_q <= dec_from_cpu;
              data_q     <= in_data;
              if (dec_mfc1) begin
                mfc1_valid_q <= 1'b1;
              end else if (dec_lat <= CNT_W'(1)) begin
                state_q    <= ST_WB;
                in_ready_q <= 1'b0;
                wb_en_q    <= !dec_cmp;
                flag_en_q  <= dec_cmp;
              end else begin
                state_q    <= ST_EXEC;
                in_ready_q <= 1'b0;
                cnt_q      <= cnt_d;
              end
            end
          end
        end

        ST_EXEC: begin
          if (cnt_q == '0) begin
            state_q   <= ST_WB;
            wb_en_q   <= !is_cmp_q;
            flag_en_q <= is_cmp_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_WB: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end

        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign fpu_op      = op_q;
  assign fpu_fs      = fs_q;
  assign fpu_ft      = ft_q;
  assign wb_en       = wb_en_q;
  assign wb_fd       = fd_q;
  assign wb_from_cpu = from_cpu_q;
  assign wb_data     = data_q;
  assign flag_en     = flag_en_q;
  assign flag_idx    = fd_q[4:2];
  assign mfc1_valid  = mfc1_valid_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: stimulus pushes expected strobes with
// their due cycle, a negedge monitor pops and compares them.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_data;
  logic        in_ready;
  logic [2:0]  fpu_op;
  logic [4:0]  fpu_fs;
  logic [4:0]  fpu_ft;
  logic        wb_en;
  logic [4:0]  wb_fd;
  logic        wb_from_cpu;
  logic [31:0] wb_data;
  logic        flag_en;
  logic [2:0]  flag_idx;
  logic        mfc1_valid;
  logic        illegal;

  fpu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_inst     (in_inst),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .fpu_op      (fpu_op),
    .fpu_fs      (fpu_fs),
    .fpu_ft      (fpu_ft),
    .wb_en       (wb_en),
    .wb_fd       (wb_fd),
    .wb_from_cpu (wb_from_cpu),
    .wb_data     (wb_data),
    .flag_en     (flag_en),
    .flag_idx    (flag_idx),
    .mfc1_valid  (mfc1_valid),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // strb = {wb_en, flag_en, mfc1_valid, illegal}
  typedef struct {
    logic [3:0]  strb;
    int          cyc;
    logic [4:0]  fd;
    logic        fc;
    logic [31:0] data;
    logic [2:0]  op;
    bit          chk_op;
    logic [4:0]  fs;
    logic [4:0]  ft;
    logic [2:0]  idx;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [3:0] K_WB   = 4'b1000;
  localparam logic [3:0] K_FLAG = 4'b0100;
  localparam logic [3:0] K_MFC1 = 4'b0010;
  localparam logic [3:0] K_ILL  = 4'b0001;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] fop,
                                     input logic [4:0] ft, input logic [4:0] fs,
                                     input logic [4:0] fd, input logic [5:0] fn);
    return {opc, fop, ft, fs, fd, fn};
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] strb, input logic [4:0] fd,
                                  input logic fc, input logic [31:0] data,
                                  input logic [2:0] op, input bit chk_op,
                                  input logic [4:0] fs, input logic [4:0] ft);
    exp_t e;
    e.strb = strb; e.cyc = 0; e.fd = fd; e.fc = fc; e.data = data;
    e.op = op; e.chk_op = chk_op; e.fs = fs; e.ft = ft; e.idx = fd[4:2];
    return e;
  endfunction

  // Monitor: every strobe must match the head of the scoreboard, and no
  // expected strobe may go past its due cycle unseen.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missing_strobe: expected kind %b at cycle %0d, now cycle %0d",
               sb[0].strb, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if ((wb_en | flag_en | mfc1_valid | illegal) === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_strobe at cycle %0d: got kind %b, expected none",
                 cyc, {wb_en, flag_en, mfc1_valid, illegal});
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", 64'({wb_en, flag_en, mfc1_valid, illegal}), 64'(e.strb));
        chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
        if (e.strb == K_WB) begin
          chk("wb_fd", 64'(wb_fd), 64'(e.fd));
          chk("wb_from_cpu", 64'(wb_from_cpu), 64'(e.fc));
          if (e.fc) chk("wb_data", 64'(wb_data), 64'(e.data));
          else begin
            chk("wb_fpu_fs", 64'(fpu_fs), 64'(e.fs));
            chk("wb_fpu_ft", 64'(fpu_ft), 64'(e.ft));
          end
          if (e.chk_op) chk("wb_fpu_op", 64'(fpu_op), 64'(e.op));
        end else if (e.strb == K_FLAG) begin
          chk("flag_idx", 64'(flag_idx), 64'(e.idx));
          chk("flag_fpu_op", 64'(fpu_op), 64'(e.op));
          chk("flag_fpu_fs", 64'(fpu_fs), 64'(e.fs));
          chk("flag_fpu_ft", 64'(fpu_ft), 64'(e.ft));
        end else if (e.strb == K_MFC1) begin
          chk("mfc1_fpu_fs", 64'(fpu_fs), 64'(e.fs));
        end
      end
    end
  end

  // Presents one instruction until accepted; returns the accept cycle and,
  // if push is set, schedules the expected strobe at accept + lat.
  task automatic send(input logic [31:0] inst, input logic [31:0] data, input exp_t e,
                      input int lat, input bit push, output int t_acc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_data  = data;
    t_acc    = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        t_acc = cyc;
        break;
      end
    end
    if (t_acc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed low for 40 cycles, expected high");
    end else if (push) begin
      e.cyc = t_acc + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_inst  = 32'hFFFF_FFFF;
    in_data  = 32'hA5A5_A5A5;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_strobes"}, 64'({wb_en, flag_en, mfc1_valid, illegal}), 64'd0);
    chk({tag, "_fpu_op"}, 64'(fpu_op), 64'd0);
    chk({tag, "_fpu_fs_ft"}, 64'({fpu_fs, fpu_ft}), 64'd0);
    chk({tag, "_wb_fd_idx"}, 64'({wb_fd, flag_idx}), 64'd0);
    chk({tag, "_wb_data"}, 64'(wb_data), 64'd0);
    chk({tag, "_wb_from_cpu"}, 64'(wb_from_cpu), 64'd0);
  endtask

  localparam logic [5:0] COP1 = 6'h11;
  localparam logic [4:0] ARI  = 5'h10;

  initial begin
    int t, tp, t1;
    exp_t none;
    none = mk_exp(4'b0000, 5'd0, 1'b0, 32'd0, 3'd0, 1'b0, 5'd0, 5'd0);

    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // add.s f4 = f2 + f3 (lat 3)
    send(mk(COP1, ARI, 5'd3, 5'd2, 5'd4, 6'h00), 32'd0,
         mk_exp(K_WB, 5'd4, 1'b0, 32'd0, 3'd0, 1'b1, 5'd2, 5'd3), 3, 1'b1, t);
    $display("add.s accepted at cycle %0d", t);
    tp = t;
    // sub.s queued behind add: accept at T+4
    send(mk(COP1, ARI, 5'd6, 5'd5, 5'd7, 6'h01), 32'd0,
         mk_exp(K_WB, 5'd7, 1'b0, 32'd0, 3'd1, 1'b1, 5'd5, 5'd6), 3, 1'b1, t);
    $display("sub.s accepted at cycle %0d", t);
    chk("sub_accept_after_add", 64'(t), 64'(tp + 4));
    tp = t;
    send(mk(COP1, ARI, 5'd2, 5'd1, 5'd9, 6'h02), 32'd0,
         mk_exp(K_WB, 5'd9, 1'b0, 32'd0, 3'd2, 1'b1, 5'd1, 5'd2), 4, 1'b1, t);
    $display("mul.s accepted at cycle %0d", t);
    chk("mul_accept_after_sub", 64'(t), 64'(tp + 4));
    tp = t;
    send(mk(COP1, ARI, 5'd11, 5'd10, 5'd12, 6'h03), 32'd0,
         mk_exp(K_WB, 5'd12, 1'b0, 32'd0, 3'd3, 1'b1, 5'd10, 5'd11), 10, 1'b1, t);
    $display("div.s accepted at cycle %0d", t);
    chk("div_accept_after_mul", 64'(t), 64'(tp + 5));
    tp = t;
    // mtc1 waiting behind div: accepted at T+11, write at T+12
    send(mk(COP1, 5'h04, 5'd0, 5'd0, 5'd13, 6'h00), 32'hDEAD_BEEF,
         mk_exp(K_WB, 5'd13, 1'b1, 32'hDEAD_BEEF, 3'd4, 1'b0, 5'd0, 5'd0), 1, 1'b1, t);
    $display("mtc1 accepted at cycle %0d", t);
    chk("mtc1_accept_after_div", 64'(t), 64'(tp + 11));
    tp = t;
    send(mk(COP1, ARI, 5'd0, 5'd14, 5'd15, 6'h06), 32'd0,
         mk_exp(K_WB, 5'd15, 1'b0, 32'd0, 3'd4, 1'b1, 5'd14, 5'd0), 1, 1'b1, t);
    $display("mov.s accepted at cycle %0d", t);
    chk("mov_accept_after_mtc1", 64'(t), 64'(tp + 2));
    tp = t;
    send(mk(COP1, ARI, 5'd2, 5'd1, 5'b01100, 6'h3C), 32'd0,
         mk_exp(K_FLAG, 5'b01100, 1'b0, 32'd0, 3'd6, 1'b1, 5'd1, 5'd2), 2, 1'b1, t);
    $display("c.lt.s accepted at cycle %0d", t);
    chk("clt_accept_after_mov", 64'(t), 64'(tp + 2));
    tp = t;
    send(mk(COP1, ARI, 5'd8, 5'd9, 5'b10100, 6'h32), 32'd0,
         mk_exp(K_FLAG, 5'b10100, 1'b0, 32'd0, 3'd5, 1'b1, 5'd9, 5'd8), 2, 1'b1, t);
    $display("c.eq.s accepted at cycle %0d", t);
    chk("ceq_accept_after_clt", 64'(t), 64'(tp + 3));
    tp = t;
    send(mk(COP1, ARI, 5'd30, 5'd31, 5'b11111, 6'h3E), 32'd0,
         mk_exp(K_FLAG, 5'b11111, 1'b0, 32'd0, 3'd7, 1'b1, 5'd31, 5'd30), 2, 1'b1, t);
    $display("c.le.s accepted at cycle %0d", t);
    chk("cle_accept_after_ceq", 64'(t), 64'(tp + 3));
    tp = t;
    // two back-to-back mfc1 fs=7
    send(mk(COP1, 5'h00, 5'd0, 5'd7, 5'd0, 6'h00), 32'd0,
         mk_exp(K_MFC1, 5'd0, 1'b0, 32'd0, 3'd0, 1'b0, 5'd7, 5'd0), 1, 1'b1, t);
    $display("mfc1 #1 accepted at cycle %0d", t);
    chk("mfc1a_accept_after_cle", 64'(t), 64'(tp + 3));
    tp = t;
    send(mk(COP1, 5'h00, 5'd0, 5'd7, 5'd0, 6'h00), 32'd0,
         mk_exp(K_MFC1, 5'd0, 1'b0, 32'd0, 3'd0, 1'b0, 5'd7, 5'd0), 1, 1'b1, t);
    $display("mfc1 #2 accepted at cycle %0d", t);
    chk("mfc1b_back_to_back", 64'(t), 64'(tp + 1));
    tp = t;
    // illegal fn 0x15: pulse at T+1, controller stays ready
    send(mk(COP1, ARI, 5'd1, 5'd1, 5'd1, 6'h15), 32'd0,
         mk_exp(K_ILL, 5'd0, 1'b0, 32'd0, 3'd0, 1'b0, 5'd0, 5'd0), 1, 1'b1, t);
    $display("illegal fn accepted at cycle %0d", t);
    chk("illegal_accept", 64'(t), 64'(tp + 1));
    tp = t;
    // non-COP1 opc 0x08: silently dropped
    send(mk(6'h08, ARI, 5'd1, 5'd2, 5'd3, 6'h00), 32'd0, none, 1, 1'b0, t);
    $display("non-cop1 accepted at cycle %0d", t);
    chk("noncop1_accept", 64'(t), 64'(tp + 1));
    tp = t;
    send(mk(COP1, ARI, 5'd20, 5'd21, 5'd1, 6'h00), 32'd0,
         mk_exp(K_WB, 5'd1, 1'b0, 32'd0, 3'd0, 1'b1, 5'd21, 5'd20), 3, 1'b1, t);
    $display("add.s after non-cop1 accepted at cycle %0d", t);
    chk("add_after_noncop1", 64'(t), 64'(tp + 1));

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #1;

    // mul.s abandoned by reset at T+2: no write may appear
    send(mk(COP1, ARI, 5'd4, 5'd3, 5'd5, 6'h02), 32'h1111_2222, none, 4, 1'b0, t1);
    $display("mul.s (to be reset) accepted at cycle %0d", t1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(mk(COP1, 5'h04, 5'd0, 5'd0, 5'd22, 6'h00), 32'h1234_5678,
         mk_exp(K_WB, 5'd22, 1'b1, 32'h1234_5678, 3'd4, 1'b0, 5'd0, 5'd0), 1, 1'b1, t);
    $display("mtc1 after reset accepted at cycle %0d", t);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
